// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: Moore FSM with embedded ALU decoder,
// memory ready handshake and illegal-instruction flagging.
module mc_controller #(
    parameter int unsigned ALUC_W        = 3,
    parameter bit          IMM_LOGIC     = 1'b1,
    parameter bit          MEM_HANDSHAKE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              memen,
    output logic              memwrite,
    output logic              iord,
    output logic              irwrite,
    output logic              pcwrite,
    output logic              branch,
    output logic              pcen,
    output logic [1:0]        pcsrc,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic              extop,
    output logic [ALUC_W-1:0] alucontrol,
    output logic              regdst,
    output logic              memtoreg,
    output logic              regwrite,
    output logic              illegal,
    output logic [3:0]        state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_e     state_q, state_d;
    logic [5:0] op;
    logic [5:0] funct;
    logic       rdy;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic [2:0] aluc;
    logic       unused_instr;

    assign op           = instruction[31:26];
    assign funct        = instruction[5:0];
    assign rdy          = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign unused_instr = ^instruction[25:6];

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = S_FETCH;
        memen    = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        pcsrc    = 2'b00;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        extop    = 1'b0;
        aluc     = ALU_AND;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        illegal  = 1'b0;

        case (state_q)
            S_FETCH: begin
                memen   = 1'b1;
                alusrcb = 2'b01;
                aluc    = ALU_ADD;
                if (rdy) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                aluc    = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_ok) state_d = S_REX;
                        else          illegal = 1'b1;
                    end
                    OP_BEQ:  state_d = S_BEQ;
                    OP_ADDI: state_d = S_IMMEX;
                    OP_ANDI, OP_ORI: begin
                        if (IMM_LOGIC) state_d = S_IMMEX;
                        else           illegal = 1'b1;
                    end
                    OP_J:    state_d = S_JUMP;
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluc    = ALU_ADD;
                if (op == OP_LW)      state_d = S_MEMRD;
                else if (op == OP_SW) state_d = S_MEMWR;
            end
            S_MEMRD: begin
                memen   = 1'b1;
                iord    = 1'b1;
                state_d = rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                memen    = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
                state_d  = rdy ? S_FETCH : S_MEMWR;
            end
            S_REX: begin
                alusrca = 1'b1;
                aluc    = funct_alu;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQ: begin
                alusrca = 1'b1;
                aluc    = ALU_SUB;
                branch  = 1'b1;
                pcsrc   = 2'b01;
            end
            S_IMMEX, S_IMMWB: begin
                // IMMWB keeps the IMMEX ALU setup so ALUOut sees no glitch
                if (IMM_LOGIC && op == OP_ANDI) begin
                    aluc  = ALU_AND;
                    extop = 1'b1;
                end else if (IMM_LOGIC && op == OP_ORI) begin
                    aluc  = ALU_OR;
                    extop = 1'b1;
                end else begin
                    aluc  = ALU_ADD;
                end
                if (state_q == S_IMMEX) begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    state_d = S_IMMWB;
                end else begin
                    regwrite = 1'b1;
                end
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        pcen       = pcwrite | (branch & zero);
        alucontrol = '0;
        alucontrol[2:0] = aluc;
        state_o    = state_q;

        // Reset blanks every output in the same cycle, even mid-access
        if (rst) begin
            memen      = 1'b0;
            memwrite   = 1'b0;
            iord       = 1'b0;
            irwrite    = 1'b0;
            pcwrite    = 1'b0;
            branch     = 1'b0;
            pcen       = 1'b0;
            pcsrc      = 2'b00;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            extop      = 1'b0;
            alucontrol = '0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            illegal    = 1'b0;
            state_o    = '0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Table-driven bench for mc_controller: per-cycle input/expected-output vectors
// plus a short sequence on a variant with IMM_LOGIC=0, MEM_HANDSHAKE=0, ALUC_W=4.
module tb_mc_controller;

    typedef struct packed {
        logic       memen, memwrite, iord, irwrite, pcwrite, pcen, branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic [2:0] aluc;
        logic       regdst, memtoreg, regwrite, illegal;
        logic [3:0] state;
    } outs_t;

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] instr;
        logic        zero;
        logic        rdy;
        outs_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;

    logic       a_memen, a_memwrite, a_iord, a_irwrite, a_pcwrite, a_branch, a_pcen;
    logic [1:0] a_pcsrc, a_alusrcb;
    logic       a_alusrca, a_extop, a_regdst, a_memtoreg, a_regwrite, a_illegal;
    logic [2:0] a_alucontrol;
    logic [3:0] a_state;

    logic       b_memen, b_memwrite, b_iord, b_irwrite, b_pcwrite, b_branch, b_pcen;
    logic [1:0] b_pcsrc, b_alusrcb;
    logic       b_alusrca, b_extop, b_regdst, b_memtoreg, b_regwrite, b_illegal;
    logic [3:0] b_alucontrol;
    logic [3:0] b_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mc_controller #(.ALUC_W(3), .IMM_LOGIC(1'b1), .MEM_HANDSHAKE(1'b1)) u0 (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
        .memen(a_memen), .memwrite(a_memwrite), .iord(a_iord), .irwrite(a_irwrite),
        .pcwrite(a_pcwrite), .branch(a_branch), .pcen(a_pcen), .pcsrc(a_pcsrc),
        .alusrca(a_alusrca), .alusrcb(a_alusrcb), .extop(a_extop), .alucontrol(a_alucontrol),
        .regdst(a_regdst), .memtoreg(a_memtoreg), .regwrite(a_regwrite), .illegal(a_illegal),
        .state_o(a_state)
    );

    mc_controller #(.ALUC_W(4), .IMM_LOGIC(1'b0), .MEM_HANDSHAKE(1'b0)) u1 (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
        .memen(b_memen), .memwrite(b_memwrite), .iord(b_iord), .irwrite(b_irwrite),
        .pcwrite(b_pcwrite), .branch(b_branch), .pcen(b_pcen), .pcsrc(b_pcsrc),
        .alusrca(b_alusrca), .alusrcb(b_alusrcb), .extop(b_extop), .alucontrol(b_alucontrol),
        .regdst(b_regdst), .memtoreg(b_memtoreg), .regwrite(b_regwrite), .illegal(b_illegal),
        .state_o(b_state)
    );

    function automatic outs_t O(
        input logic memen, memwrite, iord, irwrite, pcwrite, pcen, branch,
        input logic [1:0] pcsrc, input logic alusrca, input logic [1:0] alusrcb,
        input logic extop, input logic [2:0] aluc,
        input logic regdst, memtoreg, regwrite, illegal, input logic [3:0] state);
        outs_t o;
        o = '{memen, memwrite, iord, irwrite, pcwrite, pcen, branch, pcsrc, alusrca,
              alusrcb, extop, aluc, regdst, memtoreg, regwrite, illegal, state};
        return o;
    endfunction

    function automatic outs_t act0();
        return O(a_memen, a_memwrite, a_iord, a_irwrite, a_pcwrite, a_pcen, a_branch,
                 a_pcsrc, a_alusrca, a_alusrcb, a_extop, a_alucontrol,
                 a_regdst, a_memtoreg, a_regwrite, a_illegal, a_state);
    endfunction

    function automatic outs_t act1();
        return O(b_memen, b_memwrite, b_iord, b_irwrite, b_pcwrite, b_pcen, b_branch,
                 b_pcsrc, b_alusrca, b_alusrcb, b_extop, b_alucontrol[2:0],
                 b_regdst, b_memtoreg, b_regwrite, b_illegal, b_state);
    endfunction

    task automatic check(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic [31:0] ins,
                       input logic z, input logic rd, input outs_t e);
        vec_t v;
        v.name = name; v.rst = r; v.instr = ins; v.zero = z; v.rdy = rd; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        outs_t Z, F1, F0, D, DI, MA, MR, MWB, MW, REXS, AWB, BQ1, BQ0;
        outs_t IXO, IWO, IXA, IWA, IXN, IWN, JMP;
        logic [31:0] LW, SW, BEQ, SLT, BADOP, SLL, ORI, J, ADDI, ANDI;

        LW = 32'h8C080004; SW = 32'hAC080008; BEQ = 32'h11090003; SLT = 32'h0109502A;
        BADOP = 32'hFC000000; SLL = 32'h00000000; ORI = 32'h34080001; J = 32'h08000010;
        ADDI = 32'h20080005; ANDI = 32'h3108000F;

        //       mem mw io ir pw pe br pcs  a  srcb  ex aluc   rd mt rw il st
        Z    = O(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 0, 0, 0, 4'd0);
        F1   = O(1, 0, 0, 1, 1, 1, 0, 2'b00, 0, 2'b01, 0, 3'b010, 0, 0, 0, 0, 4'd0);
        F0   = O(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 3'b010, 0, 0, 0, 0, 4'd0);
        D    = O(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 0, 3'b010, 0, 0, 0, 0, 4'd1);
        DI   = O(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 0, 3'b010, 0, 0, 0, 1, 4'd1);
        MA   = O(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 0, 3'b010, 0, 0, 0, 0, 4'd2);
        MR   = O(1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 0, 0, 0, 4'd3);
        MWB  = O(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 1, 1, 0, 4'd4);
        MW   = O(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 0, 0, 0, 4'd5);
        REXS = O(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 3'b111, 0, 0, 0, 0, 4'd6);
        AWB  = O(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 0, 1, 0, 4'd7);
        BQ1  = O(0, 0, 0, 0, 0, 1, 1, 2'b01, 1, 2'b00, 0, 3'b110, 0, 0, 0, 0, 4'd8);
        BQ0  = O(0, 0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 0, 3'b110, 0, 0, 0, 0, 4'd8);
        IXO  = O(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 1, 3'b001, 0, 0, 0, 0, 4'd9);
        IWO  = O(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 3'b001, 0, 0, 1, 0, 4'd10);
        IXA  = O(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 0, 3'b010, 0, 0, 0, 0, 4'd9);
        IWA  = O(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b010, 0, 0, 1, 0, 4'd10);
        IXN  = O(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 1, 3'b000, 0, 0, 0, 0, 4'd9);
        IWN  = O(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 3'b000, 0, 0, 1, 0, 4'd10);
        JMP  = O(0, 0, 0, 0, 1, 1, 0, 2'b10, 0, 2'b00, 0, 3'b000, 0, 0, 0, 0, 4'd11);

        add("rst0", 1, LW, 0, 1, Z);      add("rst1", 1, LW, 0, 1, Z);
        add("lw_f", 0, LW, 0, 1, F1);     add("lw_d", 0, LW, 0, 1, D);
        add("lw_ma", 0, LW, 1, 1, MA);    add("lw_mr", 0, LW, 0, 1, MR);
        add("lw_wb", 0, LW, 0, 1, MWB);
        add("sw_f", 0, SW, 0, 1, F1);     add("sw_d", 0, SW, 0, 1, D);
        add("sw_ma", 0, SW, 0, 1, MA);    add("sw_w0", 0, SW, 0, 0, MW);
        add("sw_w1", 0, SW, 0, 0, MW);    add("sw_w2", 0, SW, 0, 1, MW);
        add("beq1_f", 0, BEQ, 0, 1, F1);  add("beq1_d", 0, BEQ, 0, 1, D);
        add("beq1_x", 0, BEQ, 1, 1, BQ1);
        add("beq0_f", 0, BEQ, 0, 1, F1);  add("beq0_d", 0, BEQ, 0, 1, D);
        add("beq0_x", 0, BEQ, 0, 1, BQ0);
        add("slt_f", 0, SLT, 0, 1, F1);   add("slt_d", 0, SLT, 0, 1, D);
        add("slt_x", 0, SLT, 0, 1, REXS); add("slt_wb", 0, SLT, 0, 1, AWB);
        add("bad_f", 0, BADOP, 0, 1, F1); add("bad_d", 0, BADOP, 0, 1, DI);
        add("sll_f", 0, SLL, 0, 1, F1);   add("sll_d", 0, SLL, 0, 1, DI);
        add("ori_f", 0, ORI, 0, 1, F1);   add("ori_d", 0, ORI, 0, 1, D);
        add("ori_x", 0, ORI, 0, 1, IXO);  add("ori_wb", 0, ORI, 0, 1, IWO);
        add("j_f", 0, J, 0, 1, F1);       add("j_d", 0, J, 0, 1, D);
        add("j_x", 0, J, 0, 1, JMP);
        add("addi_fw", 0, ADDI, 0, 0, F0); add("addi_f", 0, ADDI, 0, 1, F1);
        add("addi_d", 0, ADDI, 0, 1, D);  add("addi_x", 0, ADDI, 0, 1, IXA);
        add("addi_wb", 0, ADDI, 0, 1, IWA);
        add("andi_f", 0, ANDI, 0, 1, F1); add("andi_d", 0, ANDI, 0, 1, D);
        add("andi_x", 0, ANDI, 0, 1, IXN); add("andi_wb", 0, ANDI, 0, 1, IWN);
        add("lw2_f", 0, LW, 0, 1, F1);    add("lw2_d", 0, LW, 0, 1, D);
        add("lw2_ma", 0, LW, 0, 1, MA);   add("lw2_mr0", 0, LW, 0, 0, MR);
        add("lw2_mr1", 0, LW, 0, 1, MR);  add("lw2_wb", 0, LW, 0, 1, MWB);
        add("swr_f", 0, SW, 0, 1, F1);    add("swr_d", 0, SW, 0, 1, D);
        add("swr_ma", 0, SW, 0, 1, MA);   add("swr_w0", 0, SW, 0, 0, MW);
        add("swr_rst", 1, SW, 0, 0, Z);
        add("post_f", 0, LW, 0, 1, F1);   add("post_d", 0, LW, 0, 1, D);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; instruction = vecs[i].instr;
            zero = vecs[i].zero; mem_ready = vecs[i].rdy;
            #1;
            check($sformatf("%0d_%s", i, vecs[i].name), act0(), vecs[i].exp);
        end

        // Variant: ori illegal without IMM_LOGIC, mem_ready ignored, 4-bit alucontrol
        @(negedge clk);
        rst = 1'b1; instruction = ORI; mem_ready = 1'b0; zero = 1'b0;
        #1;
        check("v_rst", act1(), Z);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("v_fetch", act1(), F1);
        check("u0_fetch_wait", act0(), F0);
        checks++;
        if (b_alucontrol[3] !== 1'b0) begin
            errors++;
            $display("FAIL v_aluc_msb: got %b expected 0", b_alucontrol[3]);
        end
        @(negedge clk);
        #1;
        check("v_decode_illegal", act1(), DI);
        check("u0_fetch_wait2", act0(), F0);
        @(negedge clk);
        #1;
        check("v_refetch", act1(), F1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multi-cycle MIPS control unit. It replaces the single-cycle combinational main/ALU decoder pair with a Moore-style FSM plus an embedded ALU decoder. It sits beside a multi-cycle datapath with a shared instruction/data memory, an IR, an ALUOut register and an A/B register. It adds a memory ready handshake (wait states), optional andi/ori support and illegal-instruction flagging.

Parameters:
ALUC_W, 3, alucontrol width; codes below occupy bits [2:0], upper bits are always 0 (ALUC_W >= 3).
IMM_LOGIC, 1, 1 = andi (001100) and ori (001101) are legal; 0 = both decode as illegal.
MEM_HANDSHAKE, 1, 1 = memory states wait on mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
instruction  in  32  IR contents; stable from DECODE until the next FETCH.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the access this cycle.
memen  out  1  memory access enable.
memwrite  out  1  write strobe, qualified by memen.
iord  out  1  address source: 0 = PC, 1 = ALUOut.
irwrite  out  1  load IR.
pcwrite  out  1  unconditional PC write.
branch  out  1  conditional-branch state.
pcen  out  1  pcwrite | (branch & zero).
pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
alusrca  out  1  0 = PC, 1 = A.
alusrcb  out  2  00 = B, 01 = constant 4, 10 = ext imm, 11 = signimm<<2.
extop  out  1  1 = zero-extend imm (andi/ori); 0 = sign-extend.
alucontrol  out  ALUC_W  000 and, 001 or, 010 add, 110 sub, 111 slt.
regdst  out  1  1 = rd, 0 = rt.
memtoreg  out  1  1 = memory data, 0 = ALUOut.
regwrite  out  1  register-file write enable.
illegal  out  1  one-cycle pulse in DECODE on an unsupported op or funct.
state_o  out  4  current state encoding, for debug.

Behaviour:
- States and encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, ALUWB 7, BEQ 8, IMMEX 9, IMMWB 10, JUMP 11. Encodings 12-15 go to FETCH on the next edge with all outputs 0.
- Reset: rst high at an edge puts the FSM in FETCH. While rst is high, every output is 0 and state_o = 0. This holds even mid-access: an in-flight memwrite drops in the same cycle rst rises. The first fetch begins in the first cycle after rst falls.
- Default value of every output is 0 unless listed for a state below.
- FETCH:
  - Outputs: memen = 1, alusrcb = 01, alucontrol = add.
  - If mem_ready: irwrite = 1, pcwrite = 1 (so pcen = 1), then go to DECODE. Otherwise stay in FETCH with no IR/PC write.
- DECODE:
  - Outputs: alusrcb = 11, alucontrol = add (branch target into ALUOut).
  - Next state by op: lw/sw -> MEMADR; R-type (000000) -> REX; beq -> BEQ; addi (and andi/ori when IMM_LOGIC = 1) -> IMMEX; j -> JUMP.
  - Any other op, or an R-type funct outside {add 100000, sub 100010, and 100100, or 100101, slt 101010}: illegal = 1, then FETCH. No register or memory write occurs.
- MEMADR: alusrca = 1, alusrcb = 10, add. Next state: lw -> MEMRD, sw -> MEMWR.
- MEMRD: memen = 1, iord = 1. Wait for mem_ready, then MEMWB.
- MEMWB: memtoreg = 1, regwrite = 1, regdst = 0. Then FETCH.
- MEMWR: memen = 1, memwrite = 1, iord = 1. Hold until mem_ready, then FETCH.
- REX: alusrca = 1, alusrcb = 00, alucontrol per funct. Then ALUWB.
- ALUWB: regdst = 1, regwrite = 1. Then FETCH.
- BEQ: alusrca = 1, alusrcb = 00, sub, branch = 1, pcsrc = 01. pcen = zero. Then FETCH.
- IMMEX: alusrca = 1, alusrcb = 10. Op mapping: addi -> add with extop = 0; andi -> and with extop = 1; ori -> or with extop = 1. Then IMMWB.
- IMMWB: regdst = 0, regwrite = 1. extop and alucontrol are held from IMMEX. Then FETCH.
- JUMP: pcsrc = 10, pcwrite = 1. Then FETCH.
- Latency with zero wait states (cycles from first FETCH to next FETCH): lw 5, sw 4, R 4, addi/andi/ori 4, beq 3, j 3, illegal 2.
- Each wait cycle adds exactly one cycle and repeats identical outputs.
- Outputs are decoded combinationally from state, instruction, mem_ready and zero. No output is registered.

Test Plan:
- rst high for 2 cycles, then low; lw $t0,4($0) (0x8C080004), mem_ready = 1 always -> states 0,1,2,3,4,0. regwrite = 1 with memtoreg = 1 only in state 4. irwrite/pcen = 1 only in the FETCH cycle.
- sw (0xAC080008) with mem_ready low for 2 cycles in MEMWR -> memwrite = 1 for exactly 3 cycles, iord = 1 throughout. FSM returns to FETCH after mem_ready = 1. Total 6 cycles.
- beq run twice, with zero = 1 and then zero = 0 in BEQ -> pcen = 1, pcsrc = 01 in the first case; pcen = 0 in the second; both take 3 cycles.
- R-type slt (funct 101010) -> alucontrol = 111 in REX; regdst = 1, regwrite = 1 in ALUWB.
- Illegal cases: op 111111, and R-type funct 000000 -> illegal pulses 1 cycle in DECODE, then FETCH, with no regwrite or memwrite.
- IMM_LOGIC = 0 with ori (0x34080001) -> illegal. IMM_LOGIC = 1 -> alucontrol = 001, extop = 1 in IMMEX/IMMWB.
- rst asserted during the second MEMWR wait cycle -> memwrite = 0 in that cycle, state_o = 0, and a clean FETCH after release.
